// File: rtl/mult_div_seq_if.sv
// rtl/mult_div_seq_if.sv - decoder <-> multiply/divide sequencer signal bundle
interface mult_div_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             hi_lo_wr_en;
  logic             hi_lo_sl;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             instr_stall_sl;
  logic             ready_out;
  logic             busy;
  logic             div_by_zero;

  modport master (
    output start, op, operand_a, operand_b, hi_lo_wr_en, hi_lo_sl, wr_data,
    input  hi_out, lo_out, instr_stall_sl, ready_out, busy, div_by_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b, hi_lo_wr_en, hi_lo_sl, wr_data,
    output hi_out, lo_out, instr_stall_sl, ready_out, busy, div_by_zero
  );
endinterface

// File: rtl/mult_div_seq.sv
// rtl/mult_div_seq.sv - iterative multiply/divide sequencer owning HI/LO
module mult_div_seq #(
  parameter int WIDTH = 16
) (
  input logic             clock,
  input logic             reset,
  mult_div_seq_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t             state, state_next;
  logic [1:0]         op_q;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   a_raw, a_mag, b_mag;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               dbz_q;

  logic               is_div, neg_res, in_signed;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH:0]   div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign is_div    = op_q[1];
  assign neg_res   = op_q[0] & (sign_a ^ sign_b);
  assign in_signed = bus.op[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start) state_next = PREP;
      PREP: state_next = (is_div && b_mag == '0) ? DONE : RUN;
      RUN:  if (cnt == CW'(1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Multiply keeps the multiplier in the low half and shifts the product in from the top;
  // divide keeps remainder:quotient and shifts the dividend out of the low half.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc, 1'b0};
    div_diff  = {1'b0, div_shift[2*WIDTH:WIDTH]} - {2'b00, b_mag};
    div_next  = div_diff[WIDTH+1] ? div_shift[2*WIDTH-1:0]
                                  : {div_diff[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
    prod_fix  = neg_res ? -acc : acc;
    quot_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      a_raw  <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      acc    <= '0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      dbz_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            sign_a <= in_signed & bus.operand_a[WIDTH-1];
            sign_b <= in_signed & bus.operand_b[WIDTH-1];
            a_raw  <= bus.operand_a;
            a_mag  <= (in_signed & bus.operand_a[WIDTH-1]) ? -bus.operand_a : bus.operand_a;
            b_mag  <= (in_signed & bus.operand_b[WIDTH-1]) ? -bus.operand_b : bus.operand_b;
          end else if (bus.hi_lo_wr_en) begin
            if (bus.hi_lo_sl) hi_q <= bus.wr_data;
            else              lo_q <= bus.wr_data;
          end
        end
        PREP: begin
          cnt <= CW'(WIDTH);
          if (is_div) begin
            acc <= {{WIDTH{1'b0}}, a_mag};
            if (b_mag == '0) begin
              dbz_q <= 1'b1;
              hi_q  <= a_raw;
              lo_q  <= '1;
            end else begin
              dbz_q <= 1'b0;
            end
          end else begin
            acc <= {{WIDTH{1'b0}}, b_mag};
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          acc <= is_div ? div_next : mul_next;
        end
        FIX: begin
          if (is_div) begin
            lo_q <= quot_fix;
            hi_q <= rem_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi_out         = hi_q;
  assign bus.lo_out         = lo_q;
  assign bus.div_by_zero    = dbz_q;
  assign bus.busy           = (state != IDLE);
  assign bus.ready_out      = (state == DONE);
  assign bus.instr_stall_sl = ((state == IDLE) & bus.start) | (state == PREP) |
                              (state == RUN) | (state == FIX);
endmodule

// File: tb/tb_mult_div_seq.sv
// tb/tb_mult_div_seq.sv - self-checking bench for mult_div_seq
module tb_mult_div_seq;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mult_div_seq_if #(.WIDTH(16)) bus ();
  mult_div_seq #(.WIDTH(16)) dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[12];
  vec_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input bit wr_same, input int pulse_cyc);
    vec_t        e;
    int          cyc;
    int          stalls;
    bit          got;
    bit          stable;
    logic [15:0] hi0, lo0;
    @(negedge clock);
    hi0 = bus.hi_out;
    lo0 = bus.lo_out;
    stable = 1'b1;
    bus.start = 1'b1;
    bus.op = v.op;
    bus.operand_a = v.a;
    bus.operand_b = v.b;
    if (wr_same) begin
      bus.hi_lo_wr_en = 1'b1;
      bus.hi_lo_sl = 1'b1;
      bus.wr_data = 16'h1234;
    end
    sb.push_back(v);
    #1;
    check("stall_same_cycle", {31'd0, bus.instr_stall_sl}, 32'd1);
    stalls = 1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clock);
      cyc++;
      bus.start = 1'b0;
      bus.hi_lo_wr_en = 1'b0;
      if (bus.ready_out) begin
        got = 1'b1;
      end else begin
        if (bus.instr_stall_sl) stalls++;
        if (bus.hi_out !== hi0 || bus.lo_out !== lo0) stable = 1'b0;
        if (cyc == pulse_cyc) begin
          bus.start = 1'b1;
          bus.op = 2'b10;
          bus.operand_a = 16'd100;
          bus.operand_b = 16'd7;
          bus.hi_lo_wr_en = 1'b1;
          bus.hi_lo_sl = 1'b0;
          bus.wr_data = 16'hBEEF;
        end
      end
    end
    bus.start = 1'b0;
    bus.hi_lo_wr_en = 1'b0;
    e = sb.pop_front();
    if (!got) begin
      failures++;
      checks++;
      $display("FAIL ready_timeout got=none exp=ready within %0d cycles", e.lat);
    end else begin
      check("hi", bus.hi_out, e.hi);
      check("lo", bus.lo_out, e.lo);
      check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
      check("latency", cyc, e.lat);
      check("stall_cycles", stalls, e.lat);
      check("stall_low_at_ready", {31'd0, bus.instr_stall_sl}, 32'd0);
      check("hilo_stable", {31'd0, stable}, 32'd1);
    end
  endtask

  initial begin
    vecs[0]  = '{2'b00, 16'd300,  16'd500,  16'h0002, 16'h49F0, 1'b0, 19};
    vecs[1]  = '{2'b01, 16'hFFFD, 16'd7,    16'hFFFF, 16'hFFEB, 1'b0, 19};
    vecs[2]  = '{2'b00, 16'hFFFD, 16'd7,    16'h0006, 16'hFFEB, 1'b0, 19};
    vecs[3]  = '{2'b10, 16'd100,  16'd7,    16'h0002, 16'h000E, 1'b0, 19};
    vecs[4]  = '{2'b11, 16'hFF9C, 16'd7,    16'hFFFE, 16'hFFF2, 1'b0, 19};
    vecs[5]  = '{2'b11, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 19};
    vecs[6]  = '{2'b10, 16'd5,    16'd0,    16'h0005, 16'hFFFF, 1'b1, 2};
    vecs[7]  = '{2'b00, 16'd3,    16'd4,    16'h0000, 16'h000C, 1'b1, 19};
    vecs[8]  = '{2'b10, 16'd9,    16'd2,    16'h0001, 16'h0004, 1'b0, 19};
    vecs[9]  = '{2'b11, 16'hFFF6, 16'd0,    16'hFFF6, 16'hFFFF, 1'b1, 2};
    vecs[10] = '{2'b01, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b1, 19};
    vecs[11] = '{2'b11, 16'd7,    16'hFFFE, 16'h0001, 16'hFFFD, 1'b0, 19};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.hi_lo_wr_en = 1'b0;
    bus.hi_lo_sl = 1'b0;
    bus.wr_data = '0;
    repeat (3) @(negedge clock);
    check("rst_hi", bus.hi_out, 0);
    check("rst_lo", bus.lo_out, 0);
    check("rst_stall", {31'd0, bus.instr_stall_sl}, 0);
    check("rst_ready", {31'd0, bus.ready_out}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_dbz", {31'd0, bus.div_by_zero}, 0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_op(vecs[i], 1'b0, 0);

    // mthi in idle: HI takes the data, LO keeps the last quotient
    @(negedge clock);
    bus.hi_lo_wr_en = 1'b1;
    bus.hi_lo_sl = 1'b1;
    bus.wr_data = 16'h1234;
    @(negedge clock);
    bus.hi_lo_wr_en = 1'b0;
    check("mthi_hi", bus.hi_out, 16'h1234);
    check("mthi_lo", bus.lo_out, 16'hFFFD);

    run_op('{2'b00, 16'd2, 16'd3, 16'h0000, 16'h0006, 1'b0, 19}, 1'b1, 0);
    run_op('{2'b00, 16'd300, 16'd500, 16'h0002, 16'h49F0, 1'b0, 19}, 1'b0, 5);

    // reset in RUN iteration 8 must clear everything immediately
    @(negedge clock);
    bus.hi_lo_wr_en = 1'b1;
    bus.hi_lo_sl = 1'b0;
    bus.wr_data = 16'h5555;
    @(negedge clock);
    bus.hi_lo_wr_en = 1'b0;
    bus.start = 1'b1;
    bus.op = 2'b00;
    bus.operand_a = 16'd300;
    bus.operand_b = 16'd500;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (8) @(negedge clock);
    check("busy_before_reset", {31'd0, bus.busy}, 1);
    reset = 1'b1;
    #1;
    check("midrst_hi", bus.hi_out, 0);
    check("midrst_lo", bus.lo_out, 0);
    check("midrst_busy", {31'd0, bus.busy}, 0);
    check("midrst_stall", {31'd0, bus.instr_stall_sl}, 0);
    check("midrst_ready", {31'd0, bus.ready_out}, 0);
    @(negedge clock);
    reset = 1'b0;
    run_op('{2'b00, 16'd2, 16'd3, 16'h0000, 16'h0006, 1'b0, 19}, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_div_seq.md
Name: mult_div_seq

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair of the mips16 single-cycle core.
- Accepts a mult/div request from the decoder and runs a shift-add multiply or restoring divide over WIDTH cycles.
- Holds the instruction fetch via instr_stall_sl while it runs, then writes HI/LO and pulses ready so the stalled instruction can retire.
- Also serves mthi/mtlo writes when idle.

Parameters:
- WIDTH, 16, operand width; HI/LO are each WIDTH bits; product is 2*WIDTH bits.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 multu, 01 mult (signed), 10 divu, 11 div (signed).
- operand_a  in  WIDTH  multiplicand / dividend (rs).
- operand_b  in  WIDTH  multiplier / divisor (rt).
- hi_lo_wr_en  in  1  direct write to HI or LO (mthi/mtlo).
- hi_lo_sl  in  1  direct-write select: 0 = LO, 1 = HI.
- wr_data  in  WIDTH  direct-write data.
- hi_out  out  WIDTH  HI register.
- lo_out  out  WIDTH  LO register.
- instr_stall_sl  out  1  holds PC and instruction fetch.
- ready_out  out  1  one-cycle completion pulse.
- busy  out  1  high in any state other than IDLE.
- div_by_zero  out  1  sticky flag from the last divide.

Behaviour:
- Reset (asynchronous): state = IDLE. hi_out = lo_out = 0. instr_stall_sl = 0, ready_out = 0, busy = 0, div_by_zero = 0. Reset mid-operation aborts immediately and leaves no partial HI/LO update.
- State sequence: IDLE -> PREP -> RUN -> FIX -> DONE -> IDLE.
- IDLE:
  - If start is sampled high at edge k: latch op, record operand signs, and latch operand magnitudes (two's-complement negate when op is signed and the sign bit is set). Go to PREP.
  - When start = 1, instr_stall_sl is combinationally high in the same cycle.
- PREP (cycle k+1):
  - Clear the accumulator and load iteration counter = WIDTH.
  - Divide with operand_b == 0: set div_by_zero = 1 and go straight to DONE with HI = operand_a (raw) and LO = all ones.
  - Otherwise clear div_by_zero on a divide (a multiply leaves it unchanged) and go to RUN.
- RUN (cycles k+2 .. k+WIDTH+1): one bit per cycle.
  - Multiply: if the multiplier LSB is set, add the multiplicand to the upper accumulator, then shift the 2*WIDTH accumulator right 1 with carry-in.
  - Divide: shift the remainder:quotient left 1; trial-subtract the divisor; if non-negative, keep the difference and set the quotient LSB.
  - Decrement the counter; leave RUN when it reaches 1.
- FIX (cycle k+WIDTH+2): sign correction for signed ops.
  - Product is negated if sign_a ^ sign_b.
  - Quotient is negated if sign_a ^ sign_b; remainder is negated if sign_a.
  - Write HI/LO on exit from FIX. Multiply: HI = product[2W-1:W], LO = product[W-1:0]. Divide: LO = quotient, HI = remainder.
- DONE (cycle k+WIDTH+3): ready_out = 1 for exactly this cycle and instr_stall_sl = 0, so the instruction retires. Go to IDLE.
- Stall: instr_stall_sl = (IDLE & start) | PREP | RUN | FIX.
- Latency: ready_out is high WIDTH+3 cycles after the start cycle (19 for WIDTH = 16). Divide by zero takes 2 cycles.
- Overflow: signed div of the most negative value by -1 wraps naturally (LO = 0x8000, HI = 0). No flag is raised.
- start while busy: ignored, not queued.
- Direct writes (hi_lo_wr_en):
  - Take effect at the clock edge only in IDLE with start = 0.
  - If start and hi_lo_wr_en are both high in IDLE, start wins and the write is dropped.
  - Writes while busy are dropped.
- hi_out/lo_out are stable throughout an operation; HI and LO are updated together.

Test Plan:
- multu: a = 300, b = 500, start for one cycle -> stall high for 19 cycles, ready pulse at cycle 19, HI = 0x0002, LO = 0x49F0.
- mult: a = 0xFFFD (-3), b = 7 -> HI = 0xFFFF, LO = 0xFFEB. Also multu on the same operands -> HI = 0x0006, LO = 0xFFEB.
- divu and div:
  - divu a = 100, b = 7 -> LO = 0x000E, HI = 0x0002.
  - div a = 0xFF9C (-100), b = 7 -> LO = 0xFFF2, HI = 0xFFFE.
  - div 0x8000 / 0xFFFF -> LO = 0x8000, HI = 0.
- Divide by zero: divu a = 5, b = 0 -> ready 2 cycles after start, HI = 0x0005, LO = 0xFFFF, div_by_zero = 1. A following multu leaves the flag set; a following valid divu clears it.
- Contention:
  - Pulse start again in RUN -> ignored, and the result matches the first operation.
  - hi_lo_wr_en with hi_lo_sl = 1, wr_data = 0x1234 in IDLE -> HI = 0x1234, LO unchanged.
  - The same write in the same cycle as start -> dropped.
- Reset mid-op: assert reset in RUN cycle 8 -> all outputs go to 0 immediately. After release, a new multu 2*3 gives LO = 6 with normal latency.
